uart_rx_frame: RTL and testbench

UART receive deserializer sitting directly downstream of the serial RX line driven by the APB-UART bench/interface. Synchronizes RX, oversamples it on a programmable baud tick, and assembles start/data/parity/stop frames into bytes. Presents each byte with error flags to the APB register block through a valid/ready holding register.

---
 rtl/uart_rx_pkg.sv | 26 ++
 rtl/uart_baud_tick.sv | 35 +++
 rtl/uart_rx_frame.sv | 184 ++++++++++++++++++
 tb/tb_uart_rx_frame.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/uart_rx_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : uart_rx_pkg                                                 |
// | Brief  : Shared state encoding, defaults and counter-width helper    |
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
package uart_rx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } rx_state_t;

    localparam int c_DEF_OVERSAMPLE = 16;
    localparam int c_DEF_DATA_BITS  = 8;

    // Bits needed to hold values 0..n-1
    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_baud_tick.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : uart_baud_tick                                              |
// | Brief  : Divisor counter producing a one-cycle oversample tick       |
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
module uart_baud_tick #(
    parameter int DIV_W = 16
) (
    input  logic             PCLK,
    input  logic             PRESET,
    input  logic [DIV_W-1:0] baud_div,
    input  logic             clear,
    output logic             tick
);

    logic [DIV_W-1:0] r_cnt;
    logic [DIV_W-1:0] w_last;

    // A divisor of 0 behaves as 1; >= tolerates the divisor shrinking mid-count
    assign w_last = (baud_div == '0) ? '0 : baud_div - 1'b1;
    assign tick   = ~clear & (r_cnt >= w_last);

    always_ff @(posedge PCLK) begin
        if (PRESET || clear) begin
            r_cnt <= '0;
        end else if (r_cnt >= w_last) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/uart_rx_frame.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : uart_rx_frame                                               |
// | Brief  : Oversampling UART receiver with valid/ready holding register|
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
module uart_rx_frame
    import uart_rx_pkg::*;
#(
    parameter int DATA_BITS  = c_DEF_DATA_BITS,
    parameter int OVERSAMPLE = c_DEF_OVERSAMPLE,
    parameter int DIV_W      = 16
) (
    input  logic                 PCLK,
    input  logic                 PRESET,
    input  logic                 RX,
    input  logic [DIV_W-1:0]     baud_div,
    input  logic                 parity_en,
    input  logic                 parity_odd,
    input  logic                 stop2,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 overrun,
    output logic                 busy
);

    localparam int c_TCNT_W = cnt_width(OVERSAMPLE);
    localparam int c_BCNT_W = cnt_width(DATA_BITS);

    localparam logic [c_TCNT_W-1:0] c_HALF_M1 = c_TCNT_W'(OVERSAMPLE / 2 - 1);
    localparam logic [c_TCNT_W-1:0] c_FULL_M1 = c_TCNT_W'(OVERSAMPLE - 1);
    localparam logic [c_BCNT_W-1:0] c_LAST_BIT = c_BCNT_W'(DATA_BITS - 1);

    rx_state_t r_state;
    rx_state_t w_state_nxt;

    logic                 r_rx_meta;
    logic                 r_rx_sync;
    logic                 r_rx_prev;
    logic [c_TCNT_W-1:0]  r_tcnt;
    logic [c_BCNT_W-1:0]  r_bcnt;
    logic [DATA_BITS-1:0] r_shift;
    logic                 r_perr_w;
    logic                 r_ferr_w;
    logic                 r_stop_second;
    logic                 r_par_en;
    logic                 r_par_odd;
    logic                 r_stop2;
    logic [DATA_BITS-1:0] r_rx_data;
    logic                 r_rx_valid;
    logic                 r_parity_err;
    logic                 r_frame_err;
    logic                 r_overrun;

    logic w_tick;
    logic w_start_det;
    logic w_at_pt;
    logic w_frame_end;
    logic w_ferr_final;

    // Only a falling edge seen while idle starts a frame
    assign w_start_det  = (r_state == ST_IDLE) & r_rx_prev & ~r_rx_sync;
    assign w_at_pt      = w_tick & ((r_state == ST_START) ? (r_tcnt == c_HALF_M1)
                                                           : (r_tcnt == c_FULL_M1));
    assign w_ferr_final = r_ferr_w | ~r_rx_sync;

    uart_baud_tick #(
        .DIV_W (DIV_W)
    ) u_baud_tick (
        .PCLK     (PCLK),
        .PRESET   (PRESET),
        .baud_div (baud_div),
        .clear    (w_start_det),
        .tick     (w_tick)
    );

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_frame_end = 1'b0;
        case (r_state)
            ST_IDLE:   if (w_start_det) w_state_nxt = ST_START;
            ST_START:  if (w_at_pt) w_state_nxt = r_rx_sync ? ST_IDLE : ST_DATA;
            ST_DATA:   if (w_at_pt && (r_bcnt == c_LAST_BIT))
                           w_state_nxt = r_par_en ? ST_PARITY : ST_STOP;
            ST_PARITY: if (w_at_pt) w_state_nxt = ST_STOP;
            ST_STOP: begin
                // Leave mid-stop-bit so a back-to-back start edge is not missed
                if (w_at_pt && (!r_stop2 || r_stop_second)) begin
                    w_state_nxt = ST_IDLE;
                    w_frame_end = 1'b1;
                end
            end
            default:   w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            r_rx_meta     <= 1'b1;
            r_rx_sync     <= 1'b1;
            r_rx_prev     <= 1'b1;
            r_tcnt        <= '0;
            r_bcnt        <= '0;
            r_shift       <= '0;
            r_perr_w      <= 1'b0;
            r_ferr_w      <= 1'b0;
            r_stop_second <= 1'b0;
            r_par_en      <= 1'b0;
            r_par_odd     <= 1'b0;
            r_stop2       <= 1'b0;
            r_rx_data     <= '0;
            r_rx_valid    <= 1'b0;
            r_parity_err  <= 1'b0;
            r_frame_err   <= 1'b0;
            r_overrun     <= 1'b0;
        end else begin
            r_rx_meta <= RX;
            r_rx_sync <= r_rx_meta;
            r_rx_prev <= r_rx_sync;
            r_overrun <= 1'b0;

            if (w_start_det) begin
                r_tcnt        <= '0;
                r_bcnt        <= '0;
                r_perr_w      <= 1'b0;
                r_ferr_w      <= 1'b0;
                r_stop_second <= 1'b0;
                r_par_en      <= parity_en;
                r_par_odd     <= parity_odd;
                r_stop2       <= stop2;
            end else if ((r_state != ST_IDLE) && w_tick) begin
                r_tcnt <= w_at_pt ? '0 : r_tcnt + 1'b1;
            end

            if (w_at_pt) begin
                case (r_state)
                    ST_DATA: begin
                        r_shift <= {r_rx_sync, r_shift[DATA_BITS-1:1]};
                        r_bcnt  <= r_bcnt + 1'b1;
                    end
                    ST_PARITY: r_perr_w <= ((^r_shift) ^ r_rx_sync) != r_par_odd;
                    ST_STOP: begin
                        if (!r_rx_sync) r_ferr_w <= 1'b1;
                        r_stop_second <= 1'b1;
                    end
                    default: ;
                endcase
            end

            if (w_frame_end) begin
                if (!r_rx_valid || rx_ready) begin
                    r_rx_data    <= r_shift;
                    r_parity_err <= r_perr_w;
                    r_frame_err  <= w_ferr_final;
                    r_rx_valid   <= 1'b1;
                end else begin
                    r_overrun <= 1'b1;
                end
            end else if (r_rx_valid && rx_ready) begin
                r_rx_valid <= 1'b0;
            end
        end
    end

    assign rx_data    = r_rx_data;
    assign rx_valid   = r_rx_valid;
    assign parity_err = r_parity_err;
    assign frame_err  = r_frame_err;
    assign overrun    = r_overrun;
    assign busy       = (r_state != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_frame.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : tb_uart_rx_frame                                            |
// | Brief  : Directed self-checking bench for uart_rx_frame              |
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
module tb_uart_rx_frame;

    localparam int c_BIT = 64;  // baud_div 4 x 16 oversample

    logic        PCLK;
    logic        PRESET;
    logic        RX;
    logic [15:0] baud_div;
    logic        parity_en;
    logic        parity_odd;
    logic        stop2;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic        parity_err;
    logic        frame_err;
    logic        overrun;
    logic        busy;

    int          n_vec;
    int          n_err;
    int          cap_n;
    int          ovr_n;
    int          base_n;
    int          base_ovr;
    logic [7:0]  cap_data;
    logic        cap_perr;
    logic        cap_ferr;

    uart_rx_frame dut (
        .PCLK       (PCLK),
        .PRESET     (PRESET),
        .RX         (RX),
        .baud_div   (baud_div),
        .parity_en  (parity_en),
        .parity_odd (parity_odd),
        .stop2      (stop2),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_ready   (rx_ready),
        .parity_err (parity_err),
        .frame_err  (frame_err),
        .overrun    (overrun),
        .busy       (busy)
    );

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    // Record every consumed byte and every overrun cycle
    always @(negedge PCLK) begin
        if (rx_valid && rx_ready) begin
            cap_n    <= cap_n + 1;
            cap_data <= rx_data;
            cap_perr <= parity_err;
            cap_ferr <= frame_err;
        end
        if (overrun) ovr_n <= ovr_n + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec = n_vec + 1;
        if (got !== exp) begin
            n_err = n_err + 1;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(posedge PCLK);
        #1;
    endtask

    task automatic drive_bit(input logic b);
        RX = b;
        wait_clk(c_BIT);
    endtask

    task automatic send_frame(input logic [7:0] data, input logic pbit,
                              input logic s1, input logic s2);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(data[i]);
        if (parity_en) drive_bit(pbit);
        drive_bit(s1);
        if (stop2) drive_bit(s2);
    endtask

    task automatic expect_frame(input string tag, input logic [7:0] d,
                                input logic pe, input logic fe);
        chk({tag, "_count"}, cap_n - base_n, 1);
        chk({tag, "_data"}, cap_data, d);
        chk({tag, "_perr"}, cap_perr, pe);
        chk({tag, "_ferr"}, cap_ferr, fe);
    endtask

    initial begin
        n_vec = 0; n_err = 0; cap_n = 0; ovr_n = 0;
        cap_data = '0; cap_perr = 1'b0; cap_ferr = 1'b0;
        PRESET = 1'b1; RX = 1'b1; baud_div = 16'd4; rx_ready = 1'b1;
        parity_en = 1'b0; parity_odd = 1'b0; stop2 = 1'b0;
        repeat (4) @(posedge PCLK);
        @(negedge PCLK);
        chk("rst_valid", rx_valid, 0);
        chk("rst_data", rx_data, 0);
        chk("rst_flags", {parity_err, frame_err, overrun, busy}, 0);
        @(posedge PCLK); #1;
        PRESET = 1'b0;
        wait_clk(20);

        // 8N1 0xA5
        base_n = cap_n;
        send_frame(8'hA5, 1'b0, 1'b1, 1'b1);
        wait_clk(40);
        expect_frame("a5", 8'hA5, 1'b0, 1'b0);
        chk("a5_busy", busy, 0);
        chk("a5_valid_drop", rx_valid, 0);

        // Even parity, wrong then correct bit
        parity_en = 1'b1;
        base_n = cap_n;
        send_frame(8'h5A, 1'b1, 1'b1, 1'b1);
        wait_clk(40);
        expect_frame("5a_bad", 8'h5A, 1'b1, 1'b0);
        base_n = cap_n;
        send_frame(8'h5A, 1'b0, 1'b1, 1'b1);
        wait_clk(40);
        expect_frame("5a_ok", 8'h5A, 1'b0, 1'b0);

        // Odd parity, correct bit
        parity_odd = 1'b1;
        base_n = cap_n;
        send_frame(8'h07, 1'b0, 1'b1, 1'b1);
        wait_clk(40);
        expect_frame("07_odd", 8'h07, 1'b0, 1'b0);
        parity_en = 1'b0; parity_odd = 1'b0;

        // Two stop bits, second one low
        stop2 = 1'b1;
        base_n = cap_n;
        send_frame(8'hC3, 1'b0, 1'b1, 1'b0);
        RX = 1'b1;
        wait_clk(40);
        expect_frame("c3_stop2", 8'hC3, 1'b0, 1'b1);
        stop2 = 1'b0;

        // Stop bit low then a long break: one frame only
        base_n = cap_n;
        send_frame(8'h3C, 1'b0, 1'b0, 1'b0);
        wait_clk(200);
        chk("brk_busy", busy, 0);
        RX = 1'b1;
        wait_clk(100);
        expect_frame("3c_brk", 8'h3C, 1'b0, 1'b1);

        // Short low glitch is a false start
        base_n = cap_n;
        RX = 1'b0;
        wait_clk(10);
        chk("glitch_busy_hi", busy, 1);
        wait_clk(10);
        RX = 1'b1;
        wait_clk(60);
        chk("glitch_busy_lo", busy, 0);
        chk("glitch_none", cap_n - base_n, 0);
        chk("glitch_valid", rx_valid, 0);

        // Overrun: consumer stalled across two back-to-back frames
        rx_ready = 1'b0;
        base_ovr = ovr_n;
        send_frame(8'h11, 1'b0, 1'b1, 1'b1);
        chk("ovr_first_ovr", ovr_n - base_ovr, 0);
        send_frame(8'h22, 1'b0, 1'b1, 1'b1);
        wait_clk(40);
        @(negedge PCLK);
        chk("ovr_valid", rx_valid, 1);
        chk("ovr_data", rx_data, 8'h11);
        chk("ovr_pulses", ovr_n - base_ovr, 1);
        @(posedge PCLK); #1;
        base_n = cap_n;
        rx_ready = 1'b1;
        @(negedge PCLK);
        chk("ovr_valid_hold", rx_valid, 1);
        @(negedge PCLK);
        chk("ovr_valid_fall", rx_valid, 0);
        expect_frame("ovr_consume", 8'h11, 1'b0, 1'b0);

        // Reset in the middle of the data bits of 0x77
        base_n = cap_n;
        drive_bit(1'b0);
        drive_bit(1'b1);
        drive_bit(1'b1);
        drive_bit(1'b1);
        chk("mid_busy", busy, 1);
        PRESET = 1'b1;
        RX = 1'b1;
        wait_clk(3);
        @(negedge PCLK);
        chk("mid_rst_data", rx_data, 0);
        chk("mid_rst_flags", {rx_valid, parity_err, frame_err, overrun, busy}, 0);
        @(posedge PCLK); #1;
        PRESET = 1'b0;
        wait_clk(c_BIT * 10);
        chk("mid_no_77", cap_n - base_n, 0);
        send_frame(8'h81, 1'b0, 1'b1, 1'b1);
        wait_clk(40);
        expect_frame("81_after", 8'h81, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
